// File: rtl/msrh_icache_sa.sv
// N-way set-associative VIPT instruction cache: S0 request, S1 tag compare, S2 response.
// Single-outstanding blocking L2 refill with per-set round-robin victims and a fence.i invalidate walker.
module msrh_icache_sa #(
    parameter int                  WAYS      = 4,
    parameter int                  SETS      = 64,
    parameter int                  LINE_W    = 128,
    parameter int                  VADDR_W   = 39,
    parameter int                  PADDR_W   = 56,
    parameter int                  L2_TAG_W  = 8,
    parameter logic [L2_TAG_W-1:0] IC_L2_TAG = 'h80
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_flush_valid,
    input  logic                  i_s0_valid,
    input  logic [VADDR_W-1:0]    i_s0_vaddr,
    output logic                  o_s0_ready,
    input  logic [PADDR_W-1:0]    i_s1_paddr,
    input  logic                  i_s1_tlb_miss,
    output logic                  o_s2_valid,
    output logic [VADDR_W-1:0]    o_s2_vaddr,
    output logic [LINE_W-1:0]     o_s2_data,
    output logic [LINE_W/8-1:0]   o_s2_be,
    output logic                  o_s2_miss,
    output logic [VADDR_W-1:0]    o_s2_miss_vaddr,
    input  logic                  i_inval_valid,
    output logic                  o_inval_done,
    output logic                  o_l2_req_valid,
    input  logic                  i_l2_req_ready,
    output logic [PADDR_W-1:0]    o_l2_req_addr,
    output logic [L2_TAG_W-1:0]   o_l2_req_tag,
    input  logic                  i_l2_resp_valid,
    input  logic [L2_TAG_W-1:0]   i_l2_resp_tag,
    input  logic [LINE_W-1:0]     i_l2_resp_data,
    output logic                  o_l2_resp_ready
);
    localparam int LINE_B = LINE_W / 8;
    localparam int OFS    = $clog2(LINE_B);
    localparam int IDX    = $clog2(SETS);
    localparam int TAG_W  = PADDR_W - OFS - IDX;
    localparam int WB     = (WAYS > 1) ? $clog2(WAYS) : 1;

    // Index must come from untranslated page-offset bits for VIPT to be alias-free.
    if (OFS + IDX > 12) begin : g_bad_geometry
        $error("msrh_icache_sa: index+offset exceeds 4KiB page offset");
    end

    typedef enum logic [1:0] {IDLE, REQ, RESP, INVAL} state_t;
    state_t r_state, w_state_nxt;

    logic [TAG_W-1:0]  r_tag  [WAYS][SETS];
    logic [LINE_W-1:0] r_data [WAYS][SETS];
    logic [WAYS-1:0]   r_valid[SETS];
    logic [WB-1:0]     r_rr   [SETS];

    logic                r_s1_valid;
    logic [VADDR_W-1:0]  r_s1_vaddr;
    logic [TAG_W-1:0]    r_s1_rtag [WAYS];
    logic [LINE_W-1:0]   r_s1_rdata[WAYS];
    logic [WAYS-1:0]     r_s1_rvld;

    logic                r_s2_valid, r_s2_hit, r_s2_miss;
    logic [VADDR_W-1:0]  r_s2_vaddr;
    logic [LINE_W-1:0]   r_s2_data;

    logic [PADDR_W-1:0]  r_req_addr;
    logic [IDX-1:0]      r_fill_idx;
    logic [IDX-1:0]      r_inv_cnt;
    logic                r_inval_pend;

    logic                w_s0_fire;
    logic [IDX-1:0]      w_s0_idx;
    logic [TAG_W-1:0]    w_s1_ptag;
    logic [WAYS-1:0]     w_hit_way;
    logic                w_s1_hit;
    logic [LINE_W-1:0]   w_s1_data;
    logic                w_miss_start;
    logic                w_resp_hit;
    logic [WB-1:0]       w_victim;
    logic                w_evict;
    logic                w_unused;

    assign w_unused  = &{1'b0, i_s1_paddr[OFS+IDX-1:0]};

    assign o_s0_ready = !i_reset && (r_state == IDLE) && !i_inval_valid;
    assign w_s0_fire  = i_s0_valid && o_s0_ready;
    assign w_s0_idx   = i_s0_vaddr[OFS+IDX-1:OFS];

    always_ff @(posedge i_clk) begin
        if (i_reset) r_s1_valid <= 1'b0;
        else         r_s1_valid <= w_s0_fire;
    end

    always_ff @(posedge i_clk) begin
        if (w_s0_fire) begin
            r_s1_vaddr <= i_s0_vaddr;
            r_s1_rvld  <= r_valid[w_s0_idx];
            for (int w = 0; w < WAYS; w++) begin
                r_s1_rtag[w]  <= r_tag[w][w_s0_idx];
                r_s1_rdata[w] <= r_data[w][w_s0_idx];
            end
        end
    end

    assign w_s1_ptag = i_s1_paddr[PADDR_W-1:OFS+IDX];

    always_comb begin
        w_hit_way = '0;
        w_s1_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_hit_way[w] = r_s1_rvld[w] && (r_s1_rtag[w] == w_s1_ptag);
            if (w_hit_way[w]) w_s1_data = w_s1_data | r_s1_rdata[w];
        end
    end

    assign w_s1_hit     = (|w_hit_way) && !i_s1_tlb_miss;
    assign w_miss_start = (r_state == IDLE) && r_s1_valid && !w_s1_hit &&
                          !i_s1_tlb_miss && !i_flush_valid;

    always_ff @(posedge i_clk) begin
        if (!i_reset && r_s1_valid) assert ($onehot0(w_hit_way));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s2_valid <= 1'b0;
            r_s2_hit   <= 1'b0;
            r_s2_miss  <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid && !i_flush_valid;
            r_s2_hit   <= w_s1_hit;
            r_s2_miss  <= r_s1_valid && !w_s1_hit && !i_flush_valid && (r_state == IDLE);
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_s1_valid) begin
            r_s2_vaddr <= r_s1_vaddr;
            r_s2_data  <= w_s1_data;
        end
    end

    assign o_s2_valid      = r_s2_valid && r_s2_hit && !i_flush_valid;
    assign o_s2_vaddr      = r_s2_vaddr;
    assign o_s2_data       = r_s2_data;
    assign o_s2_be         = {LINE_B{1'b1}} << r_s2_vaddr[OFS-1:0];
    assign o_s2_miss       = r_s2_miss;
    assign o_s2_miss_vaddr = r_s2_vaddr;

    assign w_resp_hit = (r_state == RESP) && i_l2_resp_valid && (i_l2_resp_tag == IC_L2_TAG);

    // Invalid ways are filled lowest-first; round-robin only advances on a real eviction.
    always_comb begin
        w_victim = r_rr[r_fill_idx];
        w_evict  = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[r_fill_idx][w]) begin
                w_victim = WB'(w);
                w_evict  = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (i_inval_valid)     w_state_nxt = INVAL;
                   else if (w_miss_start) w_state_nxt = REQ;
            REQ:   if (i_l2_req_ready)    w_state_nxt = RESP;
            RESP:  if (w_resp_hit)        w_state_nxt = (r_inval_pend || i_inval_valid) ? INVAL : IDLE;
            INVAL: if (r_inv_cnt == IDX'(SETS - 1)) w_state_nxt = IDLE;
            default:                      w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_inv_cnt    <= '0;
            r_inval_pend <= 1'b0;
            r_req_addr   <= '0;
            r_fill_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == INVAL) r_inv_cnt <= r_inv_cnt + 1'b1;
            if (r_state == INVAL)
                r_inval_pend <= 1'b0;
            else if (i_inval_valid && (r_state == REQ || r_state == RESP))
                r_inval_pend <= 1'b1;
            if (r_state == IDLE && w_state_nxt == REQ) begin
                r_req_addr <= {i_s1_paddr[PADDR_W-1:OFS], {OFS{1'b0}}};
                r_fill_idx <= r_s1_vaddr[OFS+IDX-1:OFS];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else if (r_state == INVAL) begin
            r_valid[r_inv_cnt] <= '0;
        end else if (w_resp_hit) begin
            r_valid[r_fill_idx][w_victim] <= 1'b1;
            if (w_evict)
                r_rr[r_fill_idx] <= (r_rr[r_fill_idx] == WB'(WAYS - 1)) ? '0 : r_rr[r_fill_idx] + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_resp_hit) begin
            r_tag[w_victim][r_fill_idx]  <= r_req_addr[PADDR_W-1:OFS+IDX];
            r_data[w_victim][r_fill_idx] <= i_l2_resp_data;
        end
    end

    assign o_inval_done    = !i_reset && (r_state == INVAL) && (r_inv_cnt == IDX'(SETS - 1));
    assign o_l2_req_valid  = !i_reset && (r_state == REQ);
    assign o_l2_req_addr   = r_req_addr;
    assign o_l2_req_tag    = IC_L2_TAG;
    assign o_l2_resp_ready = 1'b1;
endmodule

// File: tb/tb_msrh_icache_sa.sv
// Randomised and directed bench for msrh_icache_sa against a set/way array reference model.
// Model tracks line presence per set with lowest-invalid-first fill and per-set round-robin eviction.
module tb_msrh_icache_sa;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         s0_valid = 1'b0;
    logic [38:0]  s0_vaddr = '0;
    logic         s0_ready;
    logic [55:0]  s1_paddr = '0;
    logic         s1_tlb = 1'b0;
    logic         s2_valid;
    logic [38:0]  s2_vaddr;
    logic [127:0] s2_data;
    logic [15:0]  s2_be;
    logic         s2_miss;
    logic [38:0]  s2_miss_vaddr;
    logic         inval = 1'b0;
    logic         inval_done;
    logic         l2_req_valid;
    logic         l2_req_ready = 1'b0;
    logic [55:0]  l2_req_addr;
    logic [7:0]   l2_req_tag;
    logic         l2_resp_valid = 1'b0;
    logic [7:0]   l2_resp_tag = '0;
    logic [127:0] l2_resp_data = '0;
    logic         l2_resp_ready;

    int n_vec = 0;
    int n_err = 0;

    msrh_icache_sa dut (
        .i_clk(clk), .i_reset(rst), .i_flush_valid(flush),
        .i_s0_valid(s0_valid), .i_s0_vaddr(s0_vaddr), .o_s0_ready(s0_ready),
        .i_s1_paddr(s1_paddr), .i_s1_tlb_miss(s1_tlb),
        .o_s2_valid(s2_valid), .o_s2_vaddr(s2_vaddr), .o_s2_data(s2_data), .o_s2_be(s2_be),
        .o_s2_miss(s2_miss), .o_s2_miss_vaddr(s2_miss_vaddr),
        .i_inval_valid(inval), .o_inval_done(inval_done),
        .o_l2_req_valid(l2_req_valid), .i_l2_req_ready(l2_req_ready),
        .o_l2_req_addr(l2_req_addr), .o_l2_req_tag(l2_req_tag),
        .i_l2_resp_valid(l2_resp_valid), .i_l2_resp_tag(l2_resp_tag),
        .i_l2_resp_data(l2_resp_data), .o_l2_resp_ready(l2_resp_ready)
    );

    always #5 clk = ~clk;

    // Reference model: 64 sets x 4 ways of {present, line address tag, data}.
    bit           m_vld[64][4];
    logic [45:0]  m_tag[64][4];
    logic [127:0] m_dat[64][4];
    int           m_rr [64];

    function automatic void mdl_reset();
        for (int s = 0; s < 64; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < 4; w++) m_vld[s][w] = 1'b0;
        end
    endfunction

    function automatic void mdl_inval();
        for (int s = 0; s < 64; s++)
            for (int w = 0; w < 4; w++) m_vld[s][w] = 1'b0;
    endfunction

    function automatic void mdl_lookup(input logic [55:0] pa, output bit hit, output logic [127:0] d);
        int s = int'(pa[9:4]);
        hit = 1'b0;
        d   = '0;
        for (int w = 0; w < 4; w++)
            if (m_vld[s][w] && m_tag[s][w] == pa[55:10]) begin
                hit = 1'b1;
                d   = m_dat[s][w];
            end
    endfunction

    function automatic void mdl_fill(input logic [55:0] pa, input logic [127:0] d);
        int s = int'(pa[9:4]);
        int v = -1;
        for (int w = 3; w >= 0; w--) if (!m_vld[s][w]) v = w;
        if (v < 0) begin
            v = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % 4;
        end
        m_vld[s][v] = 1'b1;
        m_tag[s][v] = pa[55:10];
        m_dat[s][v] = d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        mdl_reset();
    endtask

    // One fetch: fire in S0, present translation in S1, sample S2 two cycles after fire.
    task automatic fetch(input logic [38:0] va, input logic [55:0] pa, input bit tlbm, input bit fl,
                         output bit rdy, output bit v, output bit m, output logic [127:0] d,
                         output logic [15:0] be, output logic [38:0] mva);
        s0_valid = 1'b1;
        s0_vaddr = va;
        rdy = s0_ready;
        tick();
        s0_valid = 1'b0;
        s1_paddr = pa;
        s1_tlb   = tlbm;
        flush    = fl;
        tick();
        flush  = 1'b0;
        s1_tlb = 1'b0;
        v = s2_valid; m = s2_miss; d = s2_data; be = s2_be; mva = s2_miss_vaddr;
    endtask

    // Serve one refill; optional stall, and pulses (inval / flush / wrong-tag response) while in RESP.
    task automatic refill(input logic [127:0] data, input int dly, input bit inv, input bit fl, input bit bad,
                          output bit seen, output logic [55:0] addr, output logic [7:0] tag,
                          output bit stable, output bit stuck);
        seen = 1'b0; stable = 1'b1; stuck = 1'b1; addr = '0; tag = '0;
        for (int i = 0; i < 20 && !l2_req_valid; i++) tick();
        if (!l2_req_valid) return;
        seen = 1'b1;
        addr = l2_req_addr;
        tag  = l2_req_tag;
        for (int i = 0; i < dly; i++) begin
            tick();
            if (!l2_req_valid || l2_req_addr !== addr) stable = 1'b0;
        end
        l2_req_ready = 1'b1;
        tick();
        l2_req_ready = 1'b0;
        if (inv || fl) begin
            inval = inv;
            flush = fl;
            tick();
            inval = 1'b0;
            flush = 1'b0;
        end
        if (bad) begin
            l2_resp_valid = 1'b1; l2_resp_tag = 8'h01; l2_resp_data = ~data;
            tick();
            l2_resp_valid = 1'b0;
            stuck = !s0_ready && !l2_req_valid && !inval_done;
        end
        l2_resp_valid = 1'b1; l2_resp_tag = 8'h80; l2_resp_data = data;
        tick();
        l2_resp_valid = 1'b0;
    endtask

    // Count cycles with ready low until the cache is idle again, and where the done pulse fell.
    task automatic inval_wait(output int nlow, output int ndone, output int done_at);
        nlow = 0; ndone = 0; done_at = -1;
        for (int i = 0; i < 300; i++) begin
            if (s0_ready) break;
            nlow++;
            if (inval_done) begin ndone++; done_at = nlow; end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        if (s0_ready !== 1'b0 || l2_req_valid !== 1'b0 || inval_done !== 1'b0) begin
            $display("FAIL reset_ctrl: got rdy=%b req=%b done=%b, want 0 0 0", s0_ready, l2_req_valid, inval_done);
            n_err++;
        end
        n_vec++;
        if (s2_valid !== 1'b0 || s2_miss !== 1'b0 || l2_req_addr !== 56'h0 || l2_resp_ready !== 1'b1) begin
            $display("FAIL reset_out: got v=%b m=%b addr=%h rr=%b, want 0 0 0 1", s2_valid, s2_miss, l2_req_addr, l2_resp_ready);
            n_err++;
        end
        n_vec++;
        rst = 1'b0;
        mdl_reset();
        tick();
        if (s0_ready !== 1'b1) begin
            $display("FAIL post_reset_ready: got %b want 1", s0_ready);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_cold_miss();
        bit rdy, v, m, seen, st, sk;
        logic [127:0] d, D;
        logic [15:0] be;
        logic [38:0] mva;
        logic [55:0] a;
        logic [7:0] t;
        D = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        fetch(39'h1004, 56'h8000_1004, 0, 0, rdy, v, m, d, be, mva);
        if (v !== 1'b0 || m !== 1'b1 || mva !== 39'h1004) begin
            $display("FAIL cold_miss: got v=%b m=%b mva=%h, want 0 1 1004", v, m, mva);
            n_err++;
        end
        n_vec++;
        refill(D, 0, 0, 0, 0, seen, a, t, st, sk);
        if (!seen || a !== 56'h8000_1000 || t !== 8'h80) begin
            $display("FAIL cold_req: got seen=%b addr=%h tag=%h, want 1 80001000 80", seen, a, t);
            n_err++;
        end
        n_vec++;
        mdl_fill(56'h8000_1004, D);
        fetch(39'h1004, 56'h8000_1004, 0, 0, rdy, v, m, d, be, mva);
        if (v !== 1'b1 || m !== 1'b0 || d !== D || be !== 16'hFFF0) begin
            $display("FAIL cold_hit: got v=%b m=%b d=%h be=%h, want 1 0 %h fff0", v, m, d, be, D);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_rr_evict();
        bit rdy, v, m, seen, st, sk;
        logic [127:0] d;
        logic [15:0] be;
        logic [38:0] mva;
        logic [55:0] a, pa;
        logic [7:0] t;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            pa = 56'h8000_0000 + 56'(k) * 56'h400;
            fetch({27'h0, pa[11:0]}, pa, 0, 0, rdy, v, m, d, be, mva);
            if (m !== 1'b1 || v !== 1'b0) begin
                $display("FAIL rr_fill_miss k=%0d: got v=%b m=%b, want 0 1", k, v, m);
                n_err++;
            end
            n_vec++;
            refill({4{32'(k + 100)}}, 0, 0, 0, 0, seen, a, t, st, sk);
            if (!seen || a !== pa) begin
                $display("FAIL rr_req k=%0d: got seen=%b addr=%h want %h", k, seen, a, pa);
                n_err++;
            end
            n_vec++;
            mdl_fill(pa, {4{32'(k + 100)}});
        end
        fetch(39'h400, 56'h8000_0400, 0, 0, rdy, v, m, d, be, mva);
        if (v !== 1'b1 || d !== {4{32'd101}}) begin
            $display("FAIL rr_k1_hit: got v=%b d=%h, want 1 %h", v, d, {4{32'd101}});
            n_err++;
        end
        n_vec++;
        fetch(39'h0, 56'h8000_0000, 0, 0, rdy, v, m, d, be, mva);
        if (v !== 1'b0 || m !== 1'b1) begin
            $display("FAIL rr_k0_evicted: got v=%b m=%b, want 0 1", v, m);
            n_err++;
        end
        n_vec++;
        refill({4{32'd100}}, 0, 0, 0, 0, seen, a, t, st, sk);
        mdl_fill(56'h8000_0000, {4{32'd100}});
    endtask

    task automatic test_l2_stall();
        bit rdy, v, m, seen, st, sk;
        logic [127:0] d, D;
        logic [15:0] be;
        logic [38:0] mva;
        logic [55:0] a;
        logic [7:0] t;
        D = 128'hCAFE_0000_1111_2222_3333_4444_5555_6666;
        fetch(39'h40_0000_0040, 56'h8000_2040, 0, 0, rdy, v, m, d, be, mva);
        refill(D, 3, 0, 0, 1, seen, a, t, st, sk);
        if (!seen || !st || a !== 56'h8000_2040) begin
            $display("FAIL stall_hold: got seen=%b stable=%b addr=%h, want 1 1 80002040", seen, st, a);
            n_err++;
        end
        n_vec++;
        if (!sk) begin
            $display("FAIL bad_tag_ignored: left RESP on a response tagged 01");
            n_err++;
        end
        n_vec++;
        mdl_fill(56'h8000_2040, D);
        fetch(39'h40_0000_0048, 56'h8000_2048, 0, 0, rdy, v, m, d, be, mva);
        if (v !== 1'b1 || d !== D || be !== 16'hFF00) begin
            $display("FAIL stall_hit: got v=%b d=%h be=%h, want 1 %h ff00", v, d, be, D);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_flush();
        bit rdy, v, m, seen, st, sk;
        logic [127:0] d, D;
        logic [15:0] be;
        logic [38:0] mva;
        logic [55:0] a;
        logic [7:0] t;
        fetch(39'h40, 56'h8000_2040, 0, 1, rdy, v, m, d, be, mva);
        if (v !== 1'b0 || m !== 1'b0) begin
            $display("FAIL flush_s1: got v=%b m=%b, want 0 0", v, m);
            n_err++;
        end
        n_vec++;
        D = 128'hF1F1_0000_0000_0000_0000_0000_0000_0077;
        fetch(39'h0c0, 56'h8000_40c0, 0, 0, rdy, v, m, d, be, mva);
        refill(D, 1, 0, 1, 0, seen, a, t, st, sk);
        mdl_fill(56'h8000_40c0, D);
        fetch(39'h0c0, 56'h8000_40c0, 0, 0, rdy, v, m, d, be, mva);
        if (v !== 1'b1 || d !== D) begin
            $display("FAIL flush_resp_install: got v=%b d=%h, want 1 %h", v, d, D);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_tlb_miss();
        bit rdy, v, m;
        int nreq;
        logic [127:0] d;
        logic [15:0] be;
        logic [38:0] mva;
        fetch(39'h7_0000_0040, 56'h8000_2040, 1, 0, rdy, v, m, d, be, mva);
        if (v !== 1'b0 || m !== 1'b1 || mva !== 39'h7_0000_0040) begin
            $display("FAIL tlb_miss: got v=%b m=%b mva=%h, want 0 1 700000040", v, m, mva);
            n_err++;
        end
        n_vec++;
        nreq = 0;
        for (int i = 0; i < 5; i++) begin
            if (l2_req_valid) nreq++;
            tick();
        end
        if (nreq != 0) begin
            $display("FAIL tlb_no_req: got %0d request cycles, want 0", nreq);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_inval();
        bit rdy, v, m, seen, st, sk;
        int nl, nd, da;
        logic [127:0] d;
        logic [15:0] be;
        logic [38:0] mva;
        logic [55:0] a;
        logic [7:0] t;
        inval = 1'b1;
        #1;
        if (s0_ready !== 1'b0) begin
            $display("FAIL inval_req_ready: got %b want 0", s0_ready);
            n_err++;
        end
        n_vec++;
        tick();
        inval = 1'b0;
        inval_wait(nl, nd, da);
        mdl_inval();
        if (nl != 64 || nd != 1 || da != 64) begin
            $display("FAIL inval_seq: got low=%0d done=%0d at=%0d, want 64 1 64", nl, nd, da);
            n_err++;
        end
        n_vec++;
        fetch(39'h40, 56'h8000_2040, 0, 0, rdy, v, m, d, be, mva);
        if (v !== 1'b0 || m !== 1'b1) begin
            $display("FAIL inval_cleared: got v=%b m=%b, want 0 1", v, m);
            n_err++;
        end
        n_vec++;
        refill(128'h5, 0, 0, 0, 0, seen, a, t, st, sk);
        mdl_fill(56'h8000_2040, 128'h5);
    endtask

    task automatic test_inval_deferred();
        bit rdy, v, m, seen, st, sk;
        int nl, nd, da;
        logic [127:0] d;
        logic [15:0] be;
        logic [38:0] mva;
        logic [55:0] a;
        logic [7:0] t;
        fetch(39'h080, 56'h8000_3080, 0, 0, rdy, v, m, d, be, mva);
        refill(128'h77, 0, 1, 0, 0, seen, a, t, st, sk);
        mdl_fill(56'h8000_3080, 128'h77);
        inval_wait(nl, nd, da);
        mdl_inval();
        if (!seen || nl != 64 || nd != 1 || da != 64) begin
            $display("FAIL inval_deferred: got seen=%b low=%0d done=%0d at=%0d, want 1 64 1 64", seen, nl, nd, da);
            n_err++;
        end
        n_vec++;
        fetch(39'h080, 56'h8000_3080, 0, 0, rdy, v, m, d, be, mva);
        if (v !== 1'b0 || m !== 1'b1) begin
            $display("FAIL inval_deferred_clear: got v=%b m=%b, want 0 1", v, m);
            n_err++;
        end
        n_vec++;
        refill(128'h78, 0, 0, 0, 0, seen, a, t, st, sk);
        mdl_fill(56'h8000_3080, 128'h78);
    endtask

    task automatic test_reset_mid_resp();
        bit rdy, v, m, seen, st, sk;
        int nreq;
        logic [127:0] d;
        logic [15:0] be;
        logic [38:0] mva;
        logic [55:0] a;
        logic [7:0] t;
        fetch(39'h100, 56'h8000_5100, 0, 0, rdy, v, m, d, be, mva);
        for (int i = 0; i < 20 && !l2_req_valid; i++) tick();
        l2_req_ready = 1'b1;
        tick();
        l2_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        if (s0_ready !== 1'b0 || l2_req_valid !== 1'b0) begin
            $display("FAIL reset_mid_resp: got rdy=%b req=%b, want 0 0", s0_ready, l2_req_valid);
            n_err++;
        end
        n_vec++;
        rst = 1'b0;
        mdl_reset();
        l2_resp_valid = 1'b1; l2_resp_tag = 8'h80; l2_resp_data = 128'hBAD;
        tick();
        l2_resp_valid = 1'b0;
        if (s0_ready !== 1'b1) begin
            $display("FAIL stale_resp_idle: got rdy=%b want 1", s0_ready);
            n_err++;
        end
        n_vec++;
        fetch(39'h100, 56'h8000_5100, 0, 0, rdy, v, m, d, be, mva);
        if (v !== 1'b0 || m !== 1'b1) begin
            $display("FAIL stale_not_written: got v=%b m=%b, want 0 1", v, m);
            n_err++;
        end
        n_vec++;
        refill(128'h51, 0, 0, 0, 0, seen, a, t, st, sk);
        mdl_fill(56'h8000_5100, 128'h51);
        fetch(39'h4, 56'h8000_1004, 0, 0, rdy, v, m, d, be, mva);
        if (v !== 1'b0 || m !== 1'b1) begin
            $display("FAIL reset_cleared: got v=%b m=%b, want 0 1", v, m);
            n_err++;
        end
        n_vec++;
        refill(128'h52, 0, 0, 0, 0, seen, a, t, st, sk);
        mdl_fill(56'h8000_1004, 128'h52);
        nreq = 0;
        if (l2_req_valid) nreq++;
        if (nreq != 0) begin
            $display("FAIL reset_refill_done: request still pending");
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_random();
        bit rdy, v, m, seen, st, sk, ehit, tlbm, fl;
        logic [127:0] d, ed, nd;
        logic [15:0] be;
        logic [38:0] mva, va;
        logic [55:0] a, pa;
        logic [7:0] t;
        for (int it = 0; it < 80; it++) begin
            pa = 56'h8000_0000 | (56'($urandom_range(0, 5)) << 10) |
                 (56'($urandom_range(0, 2)) << 4) | 56'($urandom_range(0, 15));
            va = {7'($urandom), 20'($urandom), pa[11:0]};
            tlbm = ($urandom_range(0, 9) == 0);
            fl   = !tlbm && ($urandom_range(0, 9) == 0);
            mdl_lookup(pa, ehit, ed);
            fetch(va, pa, tlbm, fl, rdy, v, m, d, be, mva);
            if (rdy !== 1'b1) begin
                $display("FAIL rnd_ready it=%0d: got %b want 1", it, rdy);
                n_err++;
            end
            n_vec++;
            if (fl) begin
                if (v !== 1'b0 || m !== 1'b0) begin
                    $display("FAIL rnd_flush it=%0d: got v=%b m=%b, want 0 0", it, v, m);
                    n_err++;
                end
                n_vec++;
            end else if (ehit && !tlbm) begin
                if (v !== 1'b1 || m !== 1'b0 || d !== ed || be !== (16'hFFFF << pa[3:0])) begin
                    $display("FAIL rnd_hit it=%0d pa=%h: got v=%b m=%b d=%h be=%h, want 1 0 %h %h",
                             it, pa, v, m, d, be, ed, 16'hFFFF << pa[3:0]);
                    n_err++;
                end
                n_vec++;
            end else begin
                if (v !== 1'b0 || m !== 1'b1 || mva !== va) begin
                    $display("FAIL rnd_miss it=%0d pa=%h: got v=%b m=%b mva=%h, want 0 1 %h", it, pa, v, m, mva, va);
                    n_err++;
                end
                n_vec++;
                if (!tlbm) begin
                    nd = {$urandom, $urandom, $urandom, $urandom};
                    refill(nd, $urandom_range(0, 2), 0, 0, 0, seen, a, t, st, sk);
                    if (!seen || a !== {pa[55:4], 4'h0} || t !== 8'h80) begin
                        $display("FAIL rnd_req it=%0d: got seen=%b addr=%h tag=%h, want 1 %h 80",
                                 it, seen, a, t, {pa[55:4], 4'h0});
                        n_err++;
                    end
                    n_vec++;
                    mdl_fill(pa, nd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_rr_evict();
        test_l2_stall();
        test_flush();
        test_tlb_miss();
        test_inval();
        test_inval_deferred();
        test_reset_mid_resp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/msrh_icache_sa.md
Name: msrh_icache_sa

Overview:
- Parametrised N-way set-associative, virtually-indexed/physically-tagged instruction cache.
- Three-stage lookup: S0 request, S1 tag compare against the TLB physical address, S2 data response.
- Blocking single-outstanding L2 refill with per-set round-robin victim choice, plus a full-cache invalidate sequencer for fence.i.
- Sits between the fetch unit and the L2 request/response channels.

Parameters:
- WAYS, 4, associativity (power of 2, ≥1).
- SETS, 64, sets per way (power of 2).
- LINE_W, 128, line/data width in bits; LINE_B = LINE_W/8.
- VADDR_W, 39, virtual address width.
- PADDR_W, 56, physical address width.
- L2_TAG_W, 8, L2 transaction tag width.
- IC_L2_TAG, 8'h80, fixed tag used for every refill request.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_flush_valid  in  1  pipeline flush; kills S1/S2 results.
- i_s0_valid  in  1  fetch request.
- i_s0_vaddr  in  VADDR_W  fetch virtual address.
- o_s0_ready  out  1  request accepted.
- i_s1_paddr  in  PADDR_W  translated address of the S1 request.
- i_s1_tlb_miss  in  1  translation failed for S1.
- o_s2_valid  out  1  hit response.
- o_s2_vaddr  out  VADDR_W  response address.
- o_s2_data  out  LINE_W  hit line.
- o_s2_be  out  LINE_B  valid bytes from the fetch offset upward.
- o_s2_miss  out  1  S2 request did not hit (replay).
- o_s2_miss_vaddr  out  VADDR_W  replay address.
- i_inval_valid  in  1  invalidate-all request (pulse).
- o_inval_done  out  1  one-cycle pulse when invalidation completes.
- o_l2_req_valid  out  1  refill request.
- i_l2_req_ready  in  1  L2 accepts.
- o_l2_req_addr  out  PADDR_W  line-aligned physical address.
- o_l2_req_tag  out  L2_TAG_W  always IC_L2_TAG.
- i_l2_resp_valid  in  1  L2 response.
- i_l2_resp_tag  in  L2_TAG_W  response tag.
- i_l2_resp_data  in  LINE_W  refill line.
- o_l2_resp_ready  out  1  tied 1.

Behaviour:
- Address split: OFS = log2(LINE_B), IDX = log2(SETS), index = addr[OFS+IDX-1:OFS]. Elaboration error if OFS+IDX > 12. Tag = paddr[PADDR_W-1:OFS+IDX].
- Reset (sync, i_reset=1): all valid bits cleared; round-robin pointers = 0; state IDLE; o_s2_valid, o_s2_miss, o_l2_req_valid, o_inval_done = 0; o_l2_req_addr = 0; o_s0_ready = 0 during reset. Reset overrides an in-progress refill or invalidate, and a later L2 response is ignored.
- o_s0_ready = (state==IDLE) & !i_inval_valid.
- Fire = i_s0_valid & o_s0_ready; tag/data RAMs are read at the S0 index.
- S1:
  - hit_way[w] = valid[w] & tag[w]==paddr tag.
  - hit = |hit_way & !i_s1_tlb_miss.
  - Multiple hits are illegal (simulation assertion).
- S2:
  - o_s2_valid = r_s2_valid & r_s2_hit & !i_flush_valid. Latency is 2 cycles from fire.
  - o_s2_data = OR of data over the one-hot hit way.
  - o_s2_be = all-ones masked below vaddr[OFS-1:0].
  - o_s2_miss registered: r_s1_valid & !hit & !i_flush_valid & state==IDLE. This includes TLB miss.
- A flush in cycle N clears r_s2_valid and suppresses S1 miss detection. An S0 request firing in cycle N is not killed.
- States:
  - IDLE: S1 valid, miss, no TLB miss, no flush → latch line-aligned paddr and index → REQ.
  - REQ: o_l2_req_valid=1, held with stable addr/tag until i_l2_req_ready → RESP.
  - RESP: on i_l2_resp_valid & tag==IC_L2_TAG:
    - Victim = lowest invalid way, else rr[index].
    - Write tag, data and valid for the victim.
    - rr[index] increments (wrap modulo WAYS) only when an eviction occurred.
    - → IDLE.
    - Responses with other tags are ignored.
  - INVAL: entered from IDLE when i_inval_valid is set. A counter walks 0..SETS-1 clearing one set per cycle in all ways. At SETS-1, pulse o_inval_done → IDLE. Total duration is SETS cycles.
- i_inval_valid during REQ/RESP is latched pending; INVAL is entered after the refill completes.
- A flush during REQ/RESP does not abort the refill; the line is still installed.
- An S1 request while not IDLE is impossible because ready was 0. S1 results in the cycle that leaves IDLE still produce o_s2_miss.
- Refill write and S0 read never coincide, since ready=0 outside IDLE.

Test Plan:
- Cold miss: fetch vaddr 0x1004, paddr 0x8000_1004 → o_s2_miss=1, L2 req addr 0x8000_1000 tag 0x80. Resp data D → refetch hits with o_s2_data=D, o_s2_be=16'hFFF0 at cycle +2.
- Fill 5 lines at set 0 (paddr 0x8000_0000 + k*0x400, k=0..4) → ways 0-3 fill invalid-first. The 5th evicts way 0 (rr 0→1), so k=0 then misses and k=1 hits.
- L2 ready low 3 cycles in REQ → o_l2_req_valid and addr held stable; a response tagged 0x01 is ignored and the state stays RESP.
- Flush the cycle after a hit fire → o_s2_valid=0; flush during RESP → line still installed, later hit.
- i_inval_valid at IDLE → o_s0_ready=0 for 64 cycles, o_inval_done pulse, every prior hit now misses. Inval during RESP is deferred until after the refill.
- TLB miss in S1 → o_s2_miss=1, no L2 request. Assert i_reset mid-RESP → state IDLE, all lines invalid, and a stale response is not written.
